// File: rtl/sub_divide_seq.sv
// sub_divide_seq: sequential inverse of the multiply-add engine.
// Computes q = (o - constant) / b and r = (o - constant) % b with a
// restoring shift-subtract divider, using the same start/done handshake
// as the multiply-add block.
//
// Optional feature macro: DIVIDE_RADIX4_EN
//   undefined: one quotient bit per DIV cycle (2W DIV cycles, done after edge 2W+2)
//   defined  : two quotient bits per DIV cycle (W DIV cycles, done after edge W+2)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   operation request, accepted in IDLE or FIN
//   o        in   2W-bit dividend before constant removal
//   constant in   W-bit value subtracted from o
//   b        in   W-bit divisor
//   q        out  2W-bit quotient (all ones on divide by zero)
//   r        out  W-bit remainder
//   done     out  result valid, held until next accepted start or reset
//   busy     out  operation in progress
//   err_div0 out  b was zero
//   err_neg  out  o < constant
//
// state | meaning
// IDLE  | waiting for start after reset
// SUB   | remove constant, detect errors, load divider
// DIV   | shift-subtract iterations
// FIN   | results valid, waiting for next start
module sub_divide_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] o,
  input  logic [W-1:0]   constant,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] q,
  output logic [W-1:0]   r,
  output logic           done,
  output logic           busy,
  output logic           err_div0,
  output logic           err_neg
);

  typedef enum logic [1:0] {IDLE, SUB, DIV, FIN} state_t;

`ifdef DIVIDE_RADIX4_EN
  localparam int CNT_INIT = W - 1;
`else
  localparam int CNT_INIT = 2 * W - 1;
`endif
  localparam int CW = (CNT_INIT < 1) ? 1 : $clog2(CNT_INIT + 1);

  state_t         state;
  logic [2*W-1:0] o_l;
  logic [W-1:0]   c_l;
  logic [W-1:0]   b_l;
  // Dividend shifts out at the MSB while quotient bits shift in at the LSB,
  // so after the last iteration this register holds the quotient.
  logic [2*W-1:0] dvd;
  // Partial remainder is always < b, so W bits suffice; the W+1-bit trial
  // value below carries the shifted-out top bit into the compare.
  logic [W-1:0]   rem;
  logic [CW-1:0]  cnt;

  logic [2*W:0]   diff;
  logic [W:0]     r1;
  logic           q1;
  logic [W-1:0]   r1n;
  logic [2*W-1:0] dvd_next;
  logic [W-1:0]   rem_next;
`ifdef DIVIDE_RADIX4_EN
  logic [W:0]     r2;
  logic           q2;
  logic [W-1:0]   r2n;
`endif

  always_comb begin
    diff = {1'b0, o_l} - {{(W+1){1'b0}}, c_l};
    r1   = {rem, dvd[2*W-1]};
    q1   = (r1 >= {1'b0, b_l});
    // Difference is < b when q1 is set, so the low W bits are exact.
    r1n  = q1 ? (r1[W-1:0] - b_l) : r1[W-1:0];
`ifdef DIVIDE_RADIX4_EN
    r2       = {r1n, dvd[2*W-2]};
    q2       = (r2 >= {1'b0, b_l});
    r2n      = q2 ? (r2[W-1:0] - b_l) : r2[W-1:0];
    dvd_next = {dvd[2*W-3:0], q1, q2};
    rem_next = r2n;
`else
    dvd_next = {dvd[2*W-2:0], q1};
    rem_next = r1n;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      r        <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err_div0 <= 1'b0;
      err_neg  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            o_l      <= o;
            c_l      <= constant;
            b_l      <= b;
            done     <= 1'b0;
            err_div0 <= 1'b0;
            err_neg  <= 1'b0;
            busy     <= 1'b1;
            state    <= SUB;
          end
        end
        SUB: begin
          if (b_l == '0) begin
            err_div0 <= 1'b1;
            q        <= '1;
            r        <= '0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FIN;
          end else if (diff[2*W]) begin
            err_neg  <= 1'b1;
            q        <= '0;
            r        <= '0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FIN;
          end else begin
            dvd   <= diff[2*W-1:0];
            rem   <= '0;
            cnt   <= CW'(CNT_INIT);
            state <= DIV;
          end
        end
        DIV: begin
          dvd <= dvd_next;
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            q     <= dvd_next;
            r     <= rem_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_divide_seq.sv
// Directed bench for sub_divide_seq: hand-computed vectors, error paths,
// restart in FIN, ignored start while busy, reset mid-operation and a
// multiply-add round trip. Latency follows DIVIDE_RADIX4_EN.
module tb_sub_divide_seq;

`ifdef DIVIDE_RADIX4_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 18;
`endif
  localparam int ELAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] o = '0;
  logic [7:0]  constant = '0;
  logic [7:0]  b = '0;
  logic [15:0] q;
  logic [7:0]  r;
  logic        done, busy, err_div0, err_neg;

  int n_pass = 0;
  int n_total = 0;

  sub_divide_seq #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .o(o), .constant(constant), .b(b),
    .q(q), .r(r), .done(done), .busy(busy), .err_div0(err_div0), .err_neg(err_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pulses start (edge 1 samples it) and waits through edge lat, checking
  // that done is low right before edge lat. Returns sampled #1 after edge lat.
  task automatic run_op(input logic [15:0] oo, input logic [7:0] cc, input logic [7:0] bb,
                        input int lat);
    @(negedge clk);
    o = oo; constant = cc; b = bb; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);
    chk("done_drop_on_start", done, 0);
    @(negedge clk);
    start = 1'b0; o = 16'hA5A5; constant = 8'h5A; b = 8'h00;
    for (int e = 2; e <= lat; e++) begin
      @(posedge clk); #1;
      if (e == lat - 1) chk("done_not_early", done, 0);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                            input logic ed0, input logic en);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_div0"}, err_div0, ed0);
    chk({tag, "_neg"}, err_neg, en);
  endtask

  initial begin
    int correct;
    logic [7:0]  rb, rc;
    logic [15:0] ra;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_div0, err_neg}, 0);
    @(negedge clk); rst = 1'b0;

    run_op(16'd1000, 8'd20, 8'd7, LAT);
    chk_result("basic", 16'd140, 8'd0, 1'b0, 1'b0);

    run_op(16'd65535, 8'd0, 8'd255, LAT);
    chk_result("max", 16'd257, 8'd0, 1'b0, 1'b0);
    // Started while in FIN: run_op checks done drops on the accepting edge.
    run_op(16'd12345, 8'd100, 8'd13, LAT);
    chk_result("fin_restart", 16'd941, 8'd12, 1'b0, 1'b0);

    run_op(16'd100, 8'd5, 8'd0, ELAT);
    chk_result("div0", 16'hFFFF, 8'd0, 1'b1, 1'b0);
    run_op(16'd3, 8'd9, 8'd0, ELAT);
    chk_result("div0_prio", 16'hFFFF, 8'd0, 1'b1, 1'b0);

    run_op(16'd10, 8'd20, 8'd3, ELAT);
    chk_result("neg", 16'd0, 8'd0, 1'b0, 1'b1);

    // Start re-pulsed at edge 5 while busy must be ignored.
    @(negedge clk);
    o = 16'd12345; constant = 8'd100; b = 8'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int e = 2; e <= LAT; e++) begin
      if (e == 5) begin o = 16'd1; constant = 8'd0; b = 8'd1; start = 1'b1; end
      @(posedge clk); #1;
      @(negedge clk); start = 1'b0;
    end
    chk_result("busy_ignore", 16'd941, 8'd12, 1'b0, 1'b0);

    // Reset asserted at edge 10 of a run.
    o = 16'd12345; constant = 8'd100; b = 8'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int e = 2; e < 10; e++) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_q", q, 0);
    chk("midrst_r", r, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    run_op(16'd12345, 8'd100, 8'd13, LAT);
    chk_result("after_rst", 16'd941, 8'd12, 1'b0, 1'b0);

    correct = 0;
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(1, 255));
      rc = 8'($urandom_range(0, 255));
      ra = 16'($urandom_range(0, (65535 - int'(rc)) / int'(rb)));
      run_op(16'(ra * rb + rc), rc, rb, LAT);
      chk("rt_q", q, ra);
      chk("rt_r", r, 0);
      if (done === 1'b1 && q === ra && r === 8'd0) correct++;
    end
    $display("round trip correct %0d/20", correct);
    chk("rt_count", correct, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
